// File: rtl/jtframe_pll_rstseq.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_pll_rstseq
// Purpose  : PLL reset pulse, lock qualification and staged per-domain reset
//            release with soft-reset, download hold and lock-loss counting.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_pll_rstseq #(
  parameter int NDOM        = 3,
  parameter int PLLRST_LEN  = 256,
  parameter int LOCK_STABLE = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int LOCK_TO     = 65536
) (
  input  logic            clk_sys,
  input  logic            RESET,
  input  logic            pll_locked,
  input  logic            rst_req,
  input  logic            downloading,
  output logic            pll_rst,
  output logic [NDOM-1:0] rst_out,
  output logic            ready,
  output logic [7:0]      lock_lost
);

  localparam int MAX_A = (PLLRST_LEN > LOCK_STABLE) ? PLLRST_LEN : LOCK_STABLE;
  localparam int MAX_B = (STAGE_GAP > LOCK_TO) ? STAGE_GAP : LOCK_TO;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP) + 1;
  localparam int IW    = $clog2(NDOM + 1);

  localparam logic [CW-1:0] PLLRST_LAST = CW'(PLLRST_LEN - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] LOCKTO_LAST = CW'(LOCK_TO - 1);
  localparam logic [IW-1:0] IDX_ALL     = IW'(NDOM);

  localparam logic [2:0] ST_PLLRST   = 3'd0;
  localparam logic [2:0] ST_WAITLOCK = 3'd1;
  localparam logic [2:0] ST_STABLE   = 3'd2;
  localparam logic [2:0] ST_STAGE    = 3'd3;
  localparam logic [2:0] ST_RUN      = 3'd4;

  logic [1:0]    r_sync;
  logic          w_lock_s;
  logic [2:0]    r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic          w_lost_inc;
  logic [7:0]    r_lost;
  logic          r_dl_blk;
  logic [CW-1:0] r_dl_cnt;
  logic          w_dl_force;
  logic          w_staging;

  assign w_lock_s   = r_sync[1];
  assign w_dl_force = downloading | r_dl_blk;
  assign w_staging  = (r_state == ST_STAGE) || (r_state == ST_RUN);
  assign lock_lost  = r_lost;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], pll_locked};
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) r_state <= ST_WAITLOCK;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_lost <= 8'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_idx <= w_idx_nxt;
      if (w_lost_inc && (r_lost != 8'hFF)) r_lost <= r_lost + 8'd1;
    end
  end

  // Game domain stays held for one stage gap after a download ends
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_dl_blk <= 1'b0;
      r_dl_cnt <= '0;
    end else if (downloading) begin
      r_dl_blk <= 1'b1;
      r_dl_cnt <= '0;
    end else if (r_dl_blk) begin
      if (r_dl_cnt == GAP_LAST) r_dl_blk <= 1'b0;
      else                      r_dl_cnt <= r_dl_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_idx_nxt  = r_idx;
    w_lost_inc = 1'b0;
    case (r_state)
      ST_PLLRST: begin
        if (r_cnt == PLLRST_LAST) begin
          w_next    = ST_WAITLOCK;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_WAITLOCK: begin
        if (w_lock_s) begin
          w_next    = ST_STABLE;
          w_cnt_nxt = '0;
        end else if (r_cnt == LOCKTO_LAST) begin
          w_next    = ST_PLLRST;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_next    = ST_WAITLOCK;
          w_cnt_nxt = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_next    = ST_STAGE;
          w_cnt_nxt = '0;
          w_idx_nxt = IW'(1);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_STAGE, ST_RUN: begin
        if (!w_lock_s) begin
          w_next     = ST_PLLRST;
          w_cnt_nxt  = '0;
          w_idx_nxt  = '0;
          w_lost_inc = 1'b1;
        end else if (rst_req) begin
          w_next    = ST_STAGE;
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
        end else if (r_state == ST_STAGE) begin
          // idx 0 only occurs right after a soft reset: release domain 0 at once
          if (r_idx == '0) begin
            w_idx_nxt = IW'(1);
            w_cnt_nxt = '0;
          end else if (r_cnt == GAP_LAST) begin
            w_cnt_nxt = '0;
            if (r_idx == IDX_ALL) w_next    = ST_RUN;
            else                  w_idx_nxt = r_idx + IW'(1);
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_next    = ST_WAITLOCK;
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst = (r_state == ST_PLLRST);
    ready   = (r_state == ST_RUN) && !w_dl_force;
    for (int i = 0; i < NDOM; i++) begin
      rst_out[i] = !(w_staging && (IW'(i) < r_idx));
    end
    if (w_dl_force) rst_out[NDOM-1] = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_pll_rstseq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_pll_rstseq
// Purpose  : Scoreboard bench: expected output-change events derived from the
//            sequencing rules, compared by an independent change monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_pll_rstseq;
  localparam int NDOM = 3, PLLRST_LEN = 8, LOCK_STABLE = 16, STAGE_GAP = 4, LOCK_TO = 64;
  localparam int BIG = 32'h3fffffff;
  localparam logic [12:0] RST_VAL = {1'b0, 3'b111, 1'b0, 8'd0};

  logic clk_sys = 1'b0;
  logic RESET, pll_locked, rst_req, downloading;
  logic pll_rst, ready;
  logic [NDOM-1:0] rst_out;
  logic [7:0] lock_lost;

  jtframe_pll_rstseq #(
    .NDOM(NDOM), .PLLRST_LEN(PLLRST_LEN), .LOCK_STABLE(LOCK_STABLE),
    .STAGE_GAP(STAGE_GAP), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .pll_locked(pll_locked), .rst_req(rst_req),
    .downloading(downloading), .pll_rst(pll_rst), .rst_out(rst_out),
    .ready(ready), .lock_lost(lock_lost)
  );

  always #5 clk_sys = ~clk_sys;

  // Edge number since RESET fell: after edge n, cyc == n
  int cyc;
  always @(posedge clk_sys or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct { int cyc; logic [12:0] val; } ev_t;
  ev_t sb[$];
  int checks = 0, failures = 0;

  logic       m_pr, m_rdy;
  logic [2:0] m_ro;
  logic [7:0] m_lost;
  int         m_W;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic push(input int c);
    ev_t e;
    e.cyc = c;
    e.val = {m_pr, m_ro, m_rdy, m_lost};
    sb.push_back(e);
  endtask

  task automatic mset(input logic pr, input logic [2:0] ro, input logic rdy);
    m_pr = pr; m_ro = ro; m_rdy = rdy;
  endtask

  // Domain 0 released at t0, then one domain per gap, ready one gap after the last
  task automatic model_stage(input int t0, input int lim);
    if (t0 < lim)      begin m_ro = 3'b110; push(t0);      end
    if (t0 + 4 < lim)  begin m_ro = 3'b100; push(t0 + 4);  end
    if (t0 + 8 < lim)  begin m_ro = 3'b000; push(t0 + 8);  end
    if (t0 + 12 < lim) begin m_rdy = 1'b1;  push(t0 + 12); end
  endtask

  task automatic model_pllrst(input int p, input bit lost);
    if (lost && m_lost != 8'd255) m_lost = m_lost + 8'd1;
    mset(1'b1, 3'b111, 1'b0); push(p);
    m_pr = 1'b0;              push(p + PLLRST_LEN);
    m_W = p + PLLRST_LEN;
  endtask

  task automatic model_timeout();
    model_pllrst(m_W + LOCK_TO, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic at(input int n);
    if (cyc > n) begin
      checks++; failures++;
      $display("FAIL schedule cyc=%0d required<=%0d", cyc, n);
    end
    while (cyc < n) @(negedge clk_sys);
  endtask

  // Change monitor: every output change must match the next queued event
  initial begin
    logic [12:0] prev, cur;
    ev_t e;
    prev = RST_VAL;
    forever begin
      @(posedge clk_sys); #1;
      cur = {pll_rst, rst_out, ready, lock_lost};
      if (RESET) prev = RST_VAL;
      else if (cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=%h", cyc, cur, prev);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            failures++;
            $display("FAIL event cyc=%0d got=%h required cyc=%0d val=%h", cyc, cur, e.cyc, e.val);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int n, n2, p, s, t0, q, len, d, u, g, nn;
    RESET = 1'b1; pll_locked = 1'b1; rst_req = 1'b0; downloading = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("reset_pll_rst", int'(pll_rst), 0);
    chk("reset_rst_out", int'(rst_out), 7);
    chk("reset_ready", int'(ready), 0);
    chk("reset_lock_lost", int'(lock_lost), 0);
    RESET = 1'b0;

    // Power-up with lock already present
    m_W = 0; m_lost = 8'd0; mset(1'b0, 3'b111, 1'b0);
    t0 = imax(m_W + 1, 3) + LOCK_STABLE;
    model_stage(t0, BIG);

    // Lock loss in RUN, two lock timeouts, then relock
    n = t0 + 12 + int'($urandom_range(2, 20));
    at(n); pll_locked = 1'b0;
    model_pllrst(n + 3, 1'b1);
    model_timeout();
    model_timeout();
    n2 = m_W - 6 + int'($urandom_range(0, 40));
    at(n2); pll_locked = 1'b1;
    s = imax(m_W + 1, n2 + 3);

    // 3-cycle glitch while qualifying lock restarts qualification
    g = s + int'($urandom_range(0, 12));
    at(g); pll_locked = 1'b0;
    at(g + 3); pll_locked = 1'b1;
    m_W = g + 3;
    t0 = imax(m_W + 1, g + 6) + LOCK_STABLE;
    model_stage(t0, BIG);

    // 5-cycle soft reset in RUN
    q = t0 + 12 + int'($urandom_range(2, 10));
    at(q); rst_req = 1'b1;
    mset(1'b0, 3'b111, 1'b0); push(q + 1);
    at(q + 5); rst_req = 0;
    t0 = q + 6;
    model_stage(t0, BIG);

    // Random soft reset with a download overlapping the restage
    q = t0 + 12 + int'($urandom_range(2, 10));
    len = int'($urandom_range(1, 8));
    at(q); rst_req = 1'b1;
    mset(1'b0, 3'b111, 1'b0); push(q + 1);
    t0 = q + len + 1;
    d = q + len + int'($urandom_range(0, 5));
    u = t0 + 5 + int'($urandom_range(0, 2));
    m_ro = 3'b110; push(t0);
    m_ro = 3'b100; push(t0 + 4);
    m_ro = 3'b000; push(u + 4);
    m_rdy = 1'b1;  push(t0 + 12);
    at(q + len); rst_req = 1'b0;
    at(d); downloading = 1'b1;
    at(u); downloading = 1'b0;

    // Download in RUN holds only the game domain
    d = t0 + 12 + int'($urandom_range(2, 10));
    at(d); downloading = 1'b1;
    mset(1'b0, 3'b100, 1'b0); push(d + 1);
    u = d + int'($urandom_range(3, 20));
    at(u); downloading = 1'b0;
    mset(1'b0, 3'b000, 1'b1); push(u + 4);

    // 300 lock losses during STAGE/RUN saturate the counter
    n = u + 4 + int'($urandom_range(1, 5));
    for (int i = 0; i < 300; i++) begin
      at(n); pll_locked = 1'b0;
      p = n + 3;
      model_pllrst(p, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        at(p + 1); rst_req = 1'b1;
        at(p + 1 + int'($urandom_range(1, 4))); rst_req = 1'b0;
      end
      n2 = p + 6 + int'($urandom_range(0, 6));
      at(n2); pll_locked = 1'b1;
      s = imax(m_W + 1, n2 + 3);
      t0 = s + LOCK_STABLE;
      nn = t0 - 2 + int'($urandom_range(0, 15));
      model_stage(t0, (i == 299) ? BIG : nn + 3);
      n = nn;
    end
    at(t0 + 14);
    chk("lock_lost_saturated", int'(lock_lost), 255);
    chk("pending_events", sb.size(), 0);

    // Asynchronous RESET mid-run
    @(negedge clk_sys); #3; RESET = 1'b1; #1;
    chk("midreset_pll_rst", int'(pll_rst), 0);
    chk("midreset_rst_out", int'(rst_out), 7);
    chk("midreset_ready", int'(ready), 0);
    chk("midreset_lock_lost", int'(lock_lost), 0);
    repeat (2) @(negedge clk_sys);
    RESET = 1'b0;
    m_W = 0; m_lost = 8'd0; mset(1'b0, 3'b111, 1'b0);
    model_stage(19, BIG);
    at(40);
    chk("final_pending_events", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtframe_pll_rstseq.md
JTFRAME_PLL_RSTSEQ -- requirements
Module: jtframe_pll_rstseq

Interface
REQ-001 SHALL have parameter NDOM, default 3: number of reset domains (1..4); index NDOM-1 is the game domain.
REQ-002 SHALL have parameter PLLRST_LEN, default 256: cycles pll_rst is held high.
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: cycles of continuous lock required before release.
REQ-004 SHALL have parameter STAGE_GAP, default 16: cycles between successive domain releases.
REQ-005 SHALL have parameter LOCK_TO, default 65536: cycles allowed in WAITLOCK before a PLL reset is forced.
REQ-006 SHALL have port clk_sys, input, 1: system clock.
REQ-007 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock, asynchronous to clk_sys.
REQ-009 SHALL have port rst_req, input, 1: synchronous soft-reset request (OSD, button).
REQ-010 SHALL have port downloading, input, 1: ROM download in progress.
REQ-011 SHALL have port pll_rst, output, 1: PLL reset.
REQ-012 SHALL have port rst_out, output, NDOM: per-domain active-high resets.
REQ-013 SHALL have port ready, output, 1: all domains released.
REQ-014 SHALL have port lock_lost, output, 8: saturating count of lock-loss events.

Function
REQ-015 SHALL synchronise pll_locked through two flops into lock_s; all decisions SHALL use lock_s only.
REQ-016 SHALL implement states PLLRST, WAITLOCK, STABLE, STAGE and RUN.
REQ-017 PLLRST: pll_rst=1, all rst_out=1, ready=0; after PLLRST_LEN cycles SHALL go to WAITLOCK with pll_rst=0 on the same edge.
REQ-018 WAITLOCK: the first edge seeing lock_s=1 SHALL enter STABLE with the counter cleared.
REQ-019 WAITLOCK: after LOCK_TO cycles without lock SHALL enter PLLRST.
REQ-020 STABLE: each edge with lock_s=1 SHALL increment the counter.
REQ-021 STABLE: the edge that sees counter==LOCK_STABLE-1 SHALL enter STAGE and clear rst_out[0].
REQ-022 STABLE: lock_s=0 SHALL return to WAITLOCK; this SHALL NOT count as a lock loss.
REQ-023 STAGE: every STAGE_GAP edges SHALL clear the next rst_out index in ascending order.
REQ-024 STAGE: STAGE_GAP edges after the last release SHALL enter RUN and set ready=1.
REQ-025 A lock_s falling edge in STAGE or RUN SHALL, on the next edge, enter PLLRST, set all rst_out=1, set ready=0 and increment lock_lost (saturating at 255).
REQ-026 rst_req=1 in STAGE or RUN SHALL assert all rst_out and clear ready while high; on deassertion the block SHALL re-enter STAGE from index 0 with no PLL reset.
REQ-027 rst_req SHALL be ignored in PLLRST, WAITLOCK and STABLE.
REQ-028 downloading=1 SHALL force rst_out[NDOM-1]=1 and ready=0 in every state, overriding sequencing.
REQ-029 On downloading deassertion, rst_out[NDOM-1] SHALL fall after STAGE_GAP cycles if its stage has already passed.
REQ-030 Lock loss SHALL take priority over rst_req, and rst_req SHALL take priority over stage progress.
REQ-031 Counters SHALL be sized $clog2 of the largest parameter plus 1, and SHALL never wrap.

Reset
REQ-032 While RESET is high: state=WAITLOCK, pll_rst=0, rst_out all 1, ready=0, lock_lost=0, synchroniser and counters 0.
REQ-033 Power-up SHALL NOT pulse pll_rst.
REQ-034 RESET mid-sequence SHALL abort immediately to the reset values above.

Verification
(Parameters: NDOM=3, PLLRST_LEN=8, LOCK_STABLE=16, STAGE_GAP=4, LOCK_TO=64; edge 1 = first clk_sys edge after RESET falls.)
REQ-035 With pll_locked constantly 1, the bench SHALL check: rst_out[0] low after edge 19, rst_out[1] after 23, rst_out[2] after 27, ready high after 31, pll_rst never high.
REQ-036 Drop pll_locked in RUN -> pll_rst high for exactly 8 cycles, all rst_out=1, lock_lost=1; relock -> same staged release relative to lock_s rising.
REQ-037 Hold pll_locked=0 -> pll_rst pulses 8 cycles every 64+8 cycles; lock_lost stays 0.
REQ-038 Glitch pll_locked low for 3 cycles during STABLE -> back to WAITLOCK, counter restarts, no pll_rst, lock_lost=0.
REQ-039 Pulse rst_req for 5 cycles in RUN -> all rst_out=1 during the pulse, then restaged at 4-cycle spacing, ready after 12 more cycles.
REQ-040 Assert downloading in RUN -> only rst_out[2]=1 and ready=0; on release rst_out[2] falls after 4 cycles; 300 lock losses -> lock_lost=255.
